// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// Generic pipeline-stage register that stands between two pipeline stages.
// It carries an opaque datapath bundle and a control bundle across a
// valid/ready handshake. A two-entry arrangement (main + skid) lets the
// upstream ready come purely from registered state, so backpressure never
// forms a combinational path back through the pipeline.
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   rst_i        asynchronous active-high reset
//   flush_i      squash every held entry, a same-cycle input is dropped
//   in_valid_i   upstream presents an entry
//   in_ready_o   stage can accept an entry this cycle (registered only)
//   data_i       upstream datapath bundle
//   ctrl_i       upstream control bundle (all-zero is a no-op)
//   out_valid_o  downstream entry valid
//   out_ready_i  downstream consumes the entry this cycle
//   data_o       registered datapath bundle
//   ctrl_o       registered control bundle, zero whenever out_valid_o=0
//   stall_cnt_o  saturating count of cycles with out_valid_o=1, out_ready_i=0
module pipe_stage_reg #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 12,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] data_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] data_o,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

   logic              mValid_q, mValid_d;
   logic [DATA_W-1:0] mData_q,  mData_d;
   logic [CTRL_W-1:0] mCtrl_q,  mCtrl_d;
   logic              sValid_q, sValid_d;
   logic [DATA_W-1:0] sData_q,  sData_d;
   logic [CTRL_W-1:0] sCtrl_q,  sCtrl_d;
   logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;

   logic accept;
   logic release_w;

   // Ready only depends on the skid slot being free, which keeps the
   // upstream handshake free of any combinational dependency on downstream.
   assign in_ready_o  = !sValid_q;
   assign accept      = in_valid_i & in_ready_o;
   assign release_w   = mValid_q & out_ready_i;

   assign out_valid_o = mValid_q;
   assign data_o      = mData_q;
   assign ctrl_o      = mCtrl_q;
   assign stall_cnt_o = stallCnt_q;

   // Next-state logic. Flush wins over everything. When the main slot frees
   // up, a waiting skid entry is promoted first so ordering is preserved;
   // otherwise a fresh input goes straight to main, or a bubble is inserted
   // with control zeroed while the datapath bundle keeps its last value.
   // When main is stuck, an accepted input parks in the skid slot.
   always_comb begin
      mValid_d   = mValid_q;
      mData_d    = mData_q;
      mCtrl_d    = mCtrl_q;
      sValid_d   = sValid_q;
      sData_d    = sData_q;
      sCtrl_d    = sCtrl_q;
      stallCnt_d = stallCnt_q;

      if (flush_i) begin
         mValid_d = 1'b0;
         mCtrl_d  = '0;
         sValid_d = 1'b0;
         sCtrl_d  = '0;
      end else if (!mValid_q || release_w) begin
         if (sValid_q) begin
            mValid_d = 1'b1;
            mData_d  = sData_q;
            mCtrl_d  = sCtrl_q;
            sValid_d = 1'b0;
            sCtrl_d  = '0;
         end else if (accept) begin
            mValid_d = 1'b1;
            mData_d  = data_i;
            mCtrl_d  = ctrl_i;
         end else begin
            mValid_d = 1'b0;
            mCtrl_d  = '0;
         end
      end else if (accept) begin
         sValid_d = 1'b1;
         sData_d  = data_i;
         sCtrl_d  = ctrl_i;
      end

      // Stall counting looks at this cycle's outputs, flush or not.
      if (mValid_q && !out_ready_i && (stallCnt_q != CntMax)) begin
         stallCnt_d = stallCnt_q + CntOne;
      end
   end

   // State register with asynchronous reset; everything is cleared so the
   // stage never emits X.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mValid_q   <= 1'b0;
         mData_q    <= '0;
         mCtrl_q    <= '0;
         sValid_q   <= 1'b0;
         sData_q    <= '0;
         sCtrl_q    <= '0;
         stallCnt_q <= '0;
      end else begin
         mValid_q   <= mValid_d;
         mData_q    <= mData_d;
         mCtrl_q    <= mCtrl_d;
         sValid_q   <= sValid_d;
         sData_q    <= sData_d;
         sCtrl_q    <= sCtrl_d;
         stallCnt_q <= stallCnt_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
// Directed bench for pipe_stage_reg. Entries expected to be accepted are
// pushed to a scoreboard queue when driven; a monitor pops and compares
// them whenever the DUT releases an entry downstream.
module tb_pipe_stage_reg;

   localparam int DATA_W = 32;
   localparam int CTRL_W = 12;
   localparam int CNT_W  = 4;

   logic              clk;
   logic              rst;
   logic              flush;
   logic              inValid;
   logic              inReady;
   logic [DATA_W-1:0] dataIn;
   logic [CTRL_W-1:0] ctrlIn;
   logic              outValid;
   logic              outReady;
   logic [DATA_W-1:0] dataOut;
   logic [CTRL_W-1:0] ctrlOut;
   logic [CNT_W-1:0]  stallCnt;

   logic [DATA_W+CTRL_W-1:0] sb[$];
   logic [DATA_W+CTRL_W-1:0] expEntry;
   int total = 0;
   int bad   = 0;

   pipe_stage_reg #(
      .DATA_W(DATA_W),
      .CTRL_W(CTRL_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .flush_i    (flush),
      .in_valid_i (inValid),
      .in_ready_o (inReady),
      .data_i     (dataIn),
      .ctrl_i     (ctrlIn),
      .out_valid_o(outValid),
      .out_ready_i(outReady),
      .data_o     (dataOut),
      .ctrl_o     (ctrlOut),
      .stall_cnt_o(stallCnt)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: counts it and reports a failure with tag and values.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one set of inputs; record the entry if it is expected to be accepted.
   task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                                input logic ordy, input logic fl, input logic push);
      inValid  = v;
      dataIn   = d;
      ctrlIn   = c;
      outReady = ordy;
      flush    = fl;
      if (push) sb.push_back({d, c});
   endtask

   // Advance to just after the next rising edge.
   task automatic waitCycle();
      @(posedge clk);
      #1;
   endtask

   // Monitor: mid-cycle, a valid+ready pair means the entry leaves at the
   // next edge, so it must match the oldest expected entry. While idle the
   // control bundle must read as a no-op.
   always @(negedge clk) begin
      if (outValid && outReady) begin
         if (sb.size() > 0) begin
            expEntry = sb.pop_front();
            checkOutput("stream", {dataOut, ctrlOut}, expEntry);
         end else begin
            total++;
            bad++;
            $error("[TB] FAIL unexpected_release observed=%0h expected=none", {dataOut, ctrlOut});
         end
      end else if (!outValid) begin
         checkOutput("ctrl_idle", ctrlOut, 0);
      end
   end

   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      #12;
      $display("[TB] reset state");
      checkOutput("rst_valid", outValid, 0);
      checkOutput("rst_data", dataOut, 0);
      checkOutput("rst_ctrl", ctrlOut, 0);
      checkOutput("rst_cnt", stallCnt, 0);
      checkOutput("rst_ready", inReady, 1);
      @(negedge clk);
      rst = 1'b0;
      waitCycle();

      $display("[TB] streaming");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, DATA_W'(32'h100 + 4 * i), 12'h0A5, 1'b1, 1'b0, 1'b1);
         checkOutput("stream_ready", inReady, 1);
         waitCycle();
         checkOutput("stream_data", dataOut, 32'h100 + 4 * i);
      end
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      waitCycle();
      checkOutput("stream_end_valid", outValid, 0);
      checkOutput("stream_end_data", dataOut, 32'h108);
      checkOutput("stream_cnt", stallCnt, 0);

      $display("[TB] backpressure");
      applyStimulus(1'b1, 32'h11, 12'h0A1, 1'b0, 1'b0, 1'b1);
      waitCycle();
      applyStimulus(1'b1, 32'h22, 12'h0A2, 1'b0, 1'b0, 1'b1);
      checkOutput("bp_ready_b", inReady, 1);
      waitCycle();
      checkOutput("bp_ready_full", inReady, 0);
      applyStimulus(1'b1, 32'h33, 12'h0A3, 1'b0, 1'b0, 1'b0);
      waitCycle();
      waitCycle();
      waitCycle();
      checkOutput("bp_hold_data", dataOut, 32'h11);
      checkOutput("bp_hold_ctrl", ctrlOut, 12'h0A1);
      checkOutput("bp_cnt", stallCnt, 4);
      checkOutput("bp_ready_held", inReady, 0);
      applyStimulus(1'b1, 32'h33, 12'h0A3, 1'b1, 1'b0, 1'b0);
      waitCycle();
      checkOutput("bp_b_data", dataOut, 32'h22);
      checkOutput("bp_ready_back", inReady, 1);
      applyStimulus(1'b1, 32'h33, 12'h0A3, 1'b1, 1'b0, 1'b1);
      waitCycle();
      checkOutput("bp_c_data", dataOut, 32'h33);
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      waitCycle();
      checkOutput("bp_drained", sb.size(), 0);
      checkOutput("bp_cnt_after", stallCnt, 4);

      $display("[TB] flush with both entries full");
      applyStimulus(1'b1, 32'h11, 12'h011, 1'b0, 1'b0, 1'b1);
      waitCycle();
      applyStimulus(1'b1, 32'h22, 12'h022, 1'b0, 1'b0, 1'b1);
      waitCycle();
      applyStimulus(1'b1, 32'h44, 12'h044, 1'b0, 1'b1, 1'b0);
      sb.delete();
      waitCycle();
      checkOutput("fl_valid", outValid, 0);
      checkOutput("fl_ctrl", ctrlOut, 0);
      checkOutput("fl_ready", inReady, 1);
      checkOutput("fl_data", dataOut, 32'h11);
      checkOutput("fl_cnt", stallCnt, 6);
      applyStimulus(1'b1, 32'h66, 12'h066, 1'b1, 1'b1, 1'b0);
      waitCycle();
      checkOutput("fl_accept_valid", outValid, 0);
      checkOutput("fl_accept_data", dataOut, 32'h11);
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      waitCycle();
      waitCycle();
      checkOutput("fl_quiet_valid", outValid, 0);

      $display("[TB] bubble");
      applyStimulus(1'b1, 32'h55, 12'h055, 1'b1, 1'b0, 1'b1);
      waitCycle();
      checkOutput("bub_valid", outValid, 1);
      checkOutput("bub_data", dataOut, 32'h55);
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      waitCycle();
      checkOutput("bub_valid_after", outValid, 0);
      checkOutput("bub_ctrl_after", ctrlOut, 0);
      checkOutput("bub_data_after", dataOut, 32'h55);

      $display("[TB] async reset mid-stall");
      applyStimulus(1'b1, 32'h77, 12'h077, 1'b0, 1'b0, 1'b1);
      waitCycle();
      applyStimulus(1'b1, 32'h88, 12'h088, 1'b0, 1'b0, 1'b1);
      waitCycle();
      checkOutput("ar_ready_full", inReady, 0);
      checkOutput("ar_cnt_before", stallCnt, 7);
      #2;
      rst = 1'b1;
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      sb.delete();
      #1;
      checkOutput("ar_valid", outValid, 0);
      checkOutput("ar_data", dataOut, 0);
      checkOutput("ar_ctrl", ctrlOut, 0);
      checkOutput("ar_ready", inReady, 1);
      checkOutput("ar_cnt", stallCnt, 0);
      @(negedge clk);
      rst = 1'b0;
      waitCycle();

      $display("[TB] counter saturation");
      applyStimulus(1'b1, 32'h99, 12'h099, 1'b0, 1'b0, 1'b1);
      waitCycle();
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 20; k++) begin
         waitCycle();
         if (k == 14) checkOutput("sat_cnt14", stallCnt, 14);
         if (k == 15) checkOutput("sat_cnt15", stallCnt, 15);
      end
      checkOutput("sat_cnt20", stallCnt, 15);
      checkOutput("sat_hold_data", dataOut, 32'h99);
      sb.delete();
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      waitCycle();
      checkOutput("sat_flush_valid", outValid, 0);
      checkOutput("sat_flush_cnt", stallCnt, 15);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      waitCycle();
      checkOutput("sat_final_cnt", stallCnt, 15);
      checkOutput("sb_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
